// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single frame-buffer SRAM port: read (VGA) side and
// write (renderer) side, read-priority with a write starvation limit.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no transaction in flight; grant next request on this edge
//   S_WAIT | transaction issued to SRAM controller; waiting for sram_ready
module sram_arbiter #(
  parameter int addr_bus_size = 16,
  parameter int data_bus_size = 16,
  parameter int wr_max_wait   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_start,
  input  logic [addr_bus_size-1:0] rd_addr,
  output logic [data_bus_size-1:0] rd_data,
  output logic                     rd_ready,
  input  logic                     wr_start,
  input  logic [addr_bus_size-1:0] wr_addr,
  input  logic [data_bus_size-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     sram_start,
  output logic                     sram_rw,
  output logic [addr_bus_size-1:0] sram_addr,
  output logic [data_bus_size-1:0] sram_wdata,
  input  logic                     sram_ready,
  input  logic [data_bus_size-1:0] sram_rdata,
  output logic                     busy
);

  localparam int skip_w = $clog2(wr_max_wait + 1);
  localparam logic [skip_w-1:0] skip_max = skip_w'(wr_max_wait);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_n;
  logic              rd_pend, wr_pend;
  logic              rd_req, wr_req;
  logic              grant, grant_wr, grant_rd, done;
  logic [skip_w-1:0] skip_cnt;

  // A live start counts as a request in the same cycle, so a grant needs no extra edge.
  always_comb begin
    rd_req = rd_pend | ~rd_start;
    wr_req = wr_pend | ~wr_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state == S_IDLE) begin
      if (rd_req | wr_req) state_n = S_WAIT;
    end else begin
      if (sram_ready) state_n = S_IDLE;
    end
  end

  always_comb begin
    grant    = 1'b0;
    grant_wr = 1'b0;
    done     = 1'b0;
    if (state == S_IDLE) begin
      grant    = rd_req | wr_req;
      grant_wr = wr_req & (~rd_req | (skip_cnt == skip_max));
    end else begin
      done = sram_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      wr_pend    <= 1'b0;
      skip_cnt   <= '0;
      grant_rd   <= 1'b1;
      sram_start <= 1'b1;
      sram_rw    <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_data    <= '0;
      rd_ready   <= 1'b0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sram_start <= 1'b1;
      rd_ready   <= 1'b0;
      wr_ready   <= 1'b0;
      rd_pend    <= rd_req & ~(grant & ~grant_wr);
      wr_pend    <= wr_req & ~(grant & grant_wr);

      if (grant) begin
        sram_start <= 1'b0;
        sram_rw    <= ~grant_wr;
        sram_addr  <= grant_wr ? wr_addr : rd_addr;
        if (grant_wr) sram_wdata <= wr_data;
        grant_rd   <= ~grant_wr;
        busy       <= 1'b1;
        if (grant_wr | ~wr_req)
          skip_cnt <= '0;
        else if (skip_cnt != skip_max)
          skip_cnt <= skip_cnt + skip_w'(1);
      end else if (~wr_req) begin
        skip_cnt <= '0;
      end

      if (done) begin
        busy <= 1'b0;
        if (grant_rd) begin
          rd_data  <= sram_rdata;
          rd_ready <= 1'b1;
        end else begin
          wr_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level reference model with
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_sram_arbiter;

  localparam int WMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_start, wr_start;
  logic [15:0] rd_addr, wr_addr, wr_data;
  logic [15:0] rd_data, sram_addr, sram_wdata, sram_rdata;
  logic        rd_ready, wr_ready, sram_start, sram_rw, sram_ready, busy;

  sram_arbiter #(.addr_bus_size(16), .data_bus_size(16), .wr_max_wait(WMAX)) dut (
    .clk(clk), .reset(reset),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .sram_start(sram_start), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction queues) ----------------
  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} txn_t;
  txn_t rd_q[$];
  txn_t wr_q[$];
  txn_t cur;
  bit   busy_m, m_issue, take_wr;
  int   passes;
  logic        e_start, e_rw, e_rd_ready, e_wr_ready;
  logic [15:0] e_addr, e_wdata, e_rd_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q.delete(); wr_q.delete();
      busy_m = 0; m_issue = 0; passes = 0;
      e_start = 1; e_rw = 1; e_addr = 0; e_wdata = 0; e_rd_data = 0;
      e_rd_ready = 0; e_wr_ready = 0;
    end else begin
      e_start = 1; e_rd_ready = 0; e_wr_ready = 0; m_issue = 0;
      if (!rd_start && rd_q.size() == 0) rd_q.push_back('{1'b0, rd_addr, 16'h0});
      if (!wr_start && wr_q.size() == 0) wr_q.push_back('{1'b1, wr_addr, wr_data});
      if (busy_m) begin
        if (sram_ready) begin
          busy_m = 0;
          if (cur.wr) e_wr_ready = 1;
          else begin e_rd_ready = 1; e_rd_data = sram_rdata; end
        end
      end else if (rd_q.size() + wr_q.size() > 0) begin
        take_wr = (wr_q.size() > 0) && (rd_q.size() == 0 || passes == WMAX);
        if (take_wr) begin
          cur = wr_q.pop_front();
          passes = 0;
        end else begin
          cur = rd_q.pop_front();
          passes = (wr_q.size() > 0) ? ((passes < WMAX) ? passes + 1 : WMAX) : 0;
        end
        busy_m = 1; m_issue = 1;
        e_start = 0; e_rw = !cur.wr; e_addr = cur.addr;
        if (cur.wr) e_wdata = cur.data;
      end
    end
  end

  // ---------------- SRAM controller model ----------------
  logic [15:0] mem [0:65535];
  int          lat_mode = 1;
  bit          spur_en = 0;
  int          cd = -1;
  bit          rsp_wr;
  logic [15:0] rsp_addr, rsp_data;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      cd = -1; sram_ready = 0;
    end else begin
      sram_ready = 0;
      if (m_issue) begin
        cd = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        rsp_wr = cur.wr; rsp_addr = cur.addr; rsp_data = cur.data;
      end
      if (cd == 0) begin
        sram_ready = 1;
        if (rsp_wr) mem[rsp_addr] = rsp_data;
        else sram_rdata = mem[rsp_addr];
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end else if (spur_en && !busy_m && $urandom_range(0, 3) == 0) begin
        sram_ready = 1; sram_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  logic [16:0] start_log[$];
  int rd_cnt = 0, wr_cnt = 0, cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;

  always @(posedge clk) begin
    #1;
    chk("sram_start", sram_start, e_start);
    chk("sram_rw", sram_rw, e_rw);
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_wdata", sram_wdata, e_wdata);
    chk("rd_ready", rd_ready, e_rd_ready);
    chk("wr_ready", wr_ready, e_wr_ready);
    chk("rd_data", rd_data, e_rd_data);
    chk("busy", busy, busy_m);
    if (sram_start === 1'b0) start_log.push_back({sram_rw, sram_addr});
    if (rd_ready === 1'b1) begin rd_cnt++; last_rd_cyc = cyc; end
    if (wr_ready === 1'b1) begin wr_cnt++; last_wr_cyc = cyc; end
    cyc++;
  end

  // ---------------- random traffic ----------------
  bit rand_en = 0;
  always @(negedge clk) begin
    if (rand_en && !reset) begin
      rd_start = 1; wr_start = 1;
      if (rd_q.size() == 0 && !(busy_m && !cur.wr) && $urandom_range(0, 2) == 0) begin
        rd_addr = 16'($urandom); rd_start = 0;
      end
      if (wr_q.size() == 0 && !(busy_m && cur.wr) && $urandom_range(0, 2) == 0) begin
        wr_addr = 16'($urandom); wr_data = 16'($urandom); wr_start = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pulse_rd(input logic [15:0] a);
    @(negedge clk); rd_addr = a; rd_start = 0;
    @(negedge clk); rd_start = 1;
  endtask

  task automatic pulse_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); wr_addr = a; wr_data = d; wr_start = 0;
    @(negedge clk); wr_start = 1;
  endtask

  task automatic wait_ready(input bit is_wr, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if ((is_wr ? wr_ready : rd_ready) === 1'b1) begin ok = 1; break; end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sram_start"}, sram_start, 32'd1);
    chk({tag, "_sram_rw"}, sram_rw, 32'd1);
    chk({tag, "_sram_addr"}, sram_addr, 32'd0);
    chk({tag, "_sram_wdata"}, sram_wdata, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_readies"}, {rd_ready, wr_ready}, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int b, rc, wc;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 16'h9E37 + 16'h3C1);
    reset = 1; rd_start = 1; wr_start = 1;
    rd_addr = 0; wr_addr = 0; wr_data = 0; sram_ready = 0; sram_rdata = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    @(negedge clk) reset = 0;
    repeat (2) @(posedge clk);

    // single read, 3-cycle SRAM latency
    mem[16'h1234] = 16'h0ABC; lat_mode = 3;
    b = start_log.size(); rc = rd_cnt;
    pulse_rd(16'h1234);
    wait_ready(0, "rd1_timeout");
    chk("rd1_data", rd_data, 32'h0ABC);
    chk("rd1_starts", start_log.size() - b, 32'd1);
    chk("rd1_log", start_log[b], {15'd0, 1'b1, 16'h1234});
    @(posedge clk); #1 chk("rd1_pulse_len", rd_ready, 32'd0);

    // single write
    lat_mode = 1;
    b = start_log.size(); rc = rd_cnt; wc = wr_cnt;
    pulse_wr(16'h0010, 16'h5555);
    wait_ready(1, "wr1_timeout");
    chk("wr1_wdata", sram_wdata, 32'h5555);
    chk("wr1_log", start_log[b], {15'd0, 1'b0, 16'h0010});
    chk("wr1_no_rd", rd_cnt - rc, 32'd0);
    chk("wr1_mem", mem[16'h0010], 32'h5555);

    // simultaneous read and write: read first
    b = start_log.size(); rc = rd_cnt; wc = wr_cnt;
    @(negedge clk); rd_addr = 16'h0200; wr_addr = 16'h0300; wr_data = 16'h1111;
    rd_start = 0; wr_start = 0;
    @(negedge clk); rd_start = 1; wr_start = 1;
    wait_ready(1, "sim_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("sim_starts", start_log.size() - b, 32'd2);
    chk("sim_first", start_log[b], {15'd0, 1'b1, 16'h0200});
    chk("sim_second", start_log[b+1], {15'd0, 1'b0, 16'h0300});
    chk("sim_counts", {rd_cnt - rc, wr_cnt - wc}, {32'd1, 32'd1});
    chk("sim_order", {31'd0, last_rd_cyc < last_wr_cyc}, 32'd1);

    // write starvation: write waits while reads keep arriving on each rd_ready
    lat_mode = 3;
    pulse_rd(16'h0400);
    wr_addr = 16'h0500; wr_data = 16'h7777; wr_start = 0;
    @(negedge clk); wr_start = 1;
    b = start_log.size();
    for (int k = 0; k < 5; k++) begin
      wait_ready(0, "stv_rd_timeout");
      pulse_rd(16'h0401 + 16'(k));
    end
    wait_ready(1, "stv_wr_timeout");
    wait_ready(0, "stv_last_rd_timeout");
    chk("stv_starts", start_log.size() - b, 32'd6);
    for (int k = 0; k < 4; k++) chk("stv_read_grant", start_log[b+k][16], 32'd1);
    chk("stv_write_grant", start_log[b+4], {15'd0, 1'b0, 16'h0500});
    chk("stv_after_write", start_log[b+5], {15'd0, 1'b1, 16'h0405});

    // reset while in WAIT abandons the transaction
    lat_mode = 6;
    repeat (2) @(posedge clk);
    rc = rd_cnt;
    pulse_rd(16'h2000);
    @(negedge clk); reset = 1;
    #1 chk_reset_vals("mid");
    @(negedge clk); reset = 0;
    repeat (12) @(posedge clk);
    #1 chk("mid_no_ready", rd_cnt - rc, 32'd0);
    lat_mode = 2; mem[16'h0001] = 16'hBEEF;
    b = start_log.size();
    pulse_rd(16'h0001);
    wait_ready(0, "post_rst_timeout");
    chk("post_rst_data", rd_data, 32'hBEEF);
    chk("post_rst_log", start_log[b], {15'd0, 1'b1, 16'h0001});

    // random traffic with random latency and stray sram_ready while idle
    lat_mode = -1; spur_en = 1; rand_en = 1;
    repeat (3000) @(posedge clk);
    rand_en = 0;
    @(negedge clk); rd_start = 1; wr_start = 1;
    spur_en = 0;
    repeat (40) @(posedge clk);
    #1 chk("drain_idle", busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
